// File: rtl/zap_postalu_elastic_buffer_if.sv
// Handshake bundle between post-ALU stage, elastic buffer and memory/writeback.
// Carries both ready/valid sides plus flush controls and status.
interface zap_postalu_elastic_buffer_if #(
  parameter int PAYLOAD_WDT = 256,
  parameter int EXC_WDT     = 5,
  parameter int CNT_WDT     = 2
) ();
  logic                   i_clear_from_writeback;
  logic                   i_data_mem_fault;
  logic                   i_valid;
  logic                   o_ready;
  logic [PAYLOAD_WDT-1:0] i_payload;
  logic [EXC_WDT-1:0]     i_exc;
  logic                   o_valid;
  logic                   i_ready;
  logic [PAYLOAD_WDT-1:0] o_payload;
  logic [EXC_WDT-1:0]     o_exc;
  logic [CNT_WDT-1:0]     o_count;
  logic                   o_sleep;

  modport slave (
    input  i_clear_from_writeback,
    input  i_data_mem_fault,
    input  i_valid,
    output o_ready,
    input  i_payload,
    input  i_exc,
    output o_valid,
    input  i_ready,
    output o_payload,
    output o_exc,
    output o_count,
    output o_sleep
  );

  modport master (
    output i_clear_from_writeback,
    output i_data_mem_fault,
    output i_valid,
    input  o_ready,
    output i_payload,
    output i_exc,
    input  o_valid,
    output i_ready,
    input  o_payload,
    input  o_exc,
    input  o_count,
    input  o_sleep
  );
endinterface

// File: rtl/zap_postalu_elastic_buffer.sv
// DEPTH-entry elastic buffer between post-ALU and memory/writeback.
// Sleeps after an excepting op, flushes on clear or data fault.
module zap_postalu_elastic_buffer #(
  parameter int PAYLOAD_WDT = 256,
  parameter int DEPTH       = 2,
  parameter int EXC_WDT     = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  zap_postalu_elastic_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = PAYLOAD_WDT + EXC_WDT;

  typedef enum logic {RUN, SLEEP} state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   count;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [EW-1:0]   mem [DEPTH];
  logic [EW-1:0]   head;
  logic            flush;
  logic            push;
  logic            pop;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign flush = bus.i_clear_from_writeback
               | bus.i_data_mem_fault;

  // Ready never looks at downstream ready: no comb path upstream.
  assign bus.o_ready = (count < CW'(DEPTH))
                     | (state_q == SLEEP);
  assign bus.o_valid = (count != '0);

  assign push = bus.i_valid & bus.o_ready
              & (state_q == RUN) & ~flush;
  assign pop  = bus.o_valid & bus.i_ready;

  assign head          = bus.o_valid ? mem[rd_ptr] : '0;
  assign bus.o_payload = head[PAYLOAD_WDT-1:0];
  assign bus.o_exc     = head[EW-1:PAYLOAD_WDT];
  assign bus.o_count   = count;
  assign bus.o_sleep   = (state_q == SLEEP);

  // Next state: clear beats fault beats exception-sleep.
  always_comb begin
    state_d = state_q;
    if (bus.i_clear_from_writeback)
      state_d = RUN;
    else if (bus.i_data_mem_fault)
      state_d = SLEEP;
    else if (push && (|bus.i_exc))
      state_d = SLEEP;
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      state_q <= RUN;
    else
      state_q <= state_d;
  end

  // Occupancy and pointers; a flush empties everything.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push)
        wr_ptr <= nxt(wr_ptr);
      if (pop)
        rd_ptr <= nxt(rd_ptr);
    end
  end

  // Storage is unreset; o_valid gates what is visible.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[wr_ptr] <= {bus.i_exc, bus.i_payload};
  end
endmodule

// File: tb/tb_zap_postalu_elastic_buffer.sv
// Bench: DEPTH=2 and DEPTH=3 buffers on shared stimulus,
// each compared every cycle against a queue model.
module tb_zap_postalu_elastic_buffer;
  localparam int PWD = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            valid = 1'b0;
  logic [PWD-1:0]  payload = '0;
  logic [4:0]      exc = '0;
  logic            rdy = 1'b0;
  logic            clr = 1'b0;
  logic            flt = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [PWD-1:0] got [2][64];
  int ngot [2];

  always #5 clk = ~clk;

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : ch
    localparam int D  = (g == 0) ? 2 : 3;
    localparam int CW = $clog2(D + 1);

    zap_postalu_elastic_buffer_if #(
      .PAYLOAD_WDT(PWD),
      .EXC_WDT(5),
      .CNT_WDT(CW)
    ) bus ();

    assign bus.i_clear_from_writeback = clr;
    assign bus.i_data_mem_fault       = flt;
    assign bus.i_valid                = valid;
    assign bus.i_payload              = payload;
    assign bus.i_exc                  = exc;
    assign bus.i_ready                = rdy;

    zap_postalu_elastic_buffer #(
      .PAYLOAD_WDT(PWD),
      .DEPTH(D),
      .EXC_WDT(5)
    ) dut (
      .i_clk(clk),
      .i_reset(rst),
      .bus(bus)
    );

    logic [PWD+4:0] q [$];
    logic slp = 1'b0;

    // Model: a queue of {exc,payload} plus a sleep flag.
    always @(posedge clk or posedge rst) begin
      bit rd, pp, ps;
      if (rst) begin
        q.delete();
        slp = 1'b0;
      end else begin
        rd = (q.size() < D) || slp;
        pp = (q.size() > 0) && rdy;
        ps = valid && rd && !slp;
        if (clr) begin
          q.delete();
          slp = 1'b0;
        end else if (flt) begin
          q.delete();
          slp = 1'b1;
        end else begin
          if (pp) void'(q.pop_front());
          if (ps) begin
            q.push_back({exc, payload});
            if (exc != 0) slp = 1'b1;
          end
        end
      end
    end

    // Compare every cycle; log entries the DUT hands out.
    always @(negedge clk) begin
      logic [PWD+4:0] h;
      h = (q.size() != 0) ? q[0] : '0;
      chk($sformatf("d%0d valid", D),
          64'(bus.o_valid), 64'(q.size() != 0));
      chk($sformatf("d%0d count", D),
          64'(bus.o_count), 64'(q.size()));
      chk($sformatf("d%0d ready", D),
          64'(bus.o_ready),
          64'((q.size() < D) || slp));
      chk($sformatf("d%0d sleep", D),
          64'(bus.o_sleep), 64'(slp));
      chk($sformatf("d%0d payload", D),
          64'(bus.o_payload), 64'(h[PWD-1:0]));
      chk($sformatf("d%0d exc", D),
          64'(bus.o_exc), 64'(h[PWD+4:PWD]));
      if (bus.o_valid && rdy && !rst
          && ngot[g] < 64) begin
        got[g][ngot[g]] = bus.o_payload;
        ngot[g]++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(
    input logic [PWD-1:0] p,
    input logic [4:0] e
  );
    valid = 1'b1;
    payload = p;
    exc = e;
    cyc(1);
  endtask

  int b0;
  int b1;

  initial begin
    ngot[0] = 0;
    ngot[1] = 0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    chk("rst ready", 64'(ch[0].bus.o_ready), 64'd1);
    chk("rst valid", 64'(ch[0].bus.o_valid), 64'd0);
    chk("rst count", 64'(ch[0].bus.o_count), 64'd0);
    chk("rst sleep", 64'(ch[0].bus.o_sleep), 64'd0);

    // Reset mid-stream.
    put(32'hA1, 5'd0);
    put(32'hA2, 5'd0);
    valid = 1'b0;
    chk("t1 count", 64'(ch[0].bus.o_count), 64'd2);
    #2 rst = 1'b1;
    #1;
    chk("t1 async valid",
        64'(ch[0].bus.o_valid), 64'd0);
    chk("t1 async count",
        64'(ch[0].bus.o_count), 64'd0);
    chk("t1 async ready",
        64'(ch[0].bus.o_ready), 64'd1);
    cyc(1);
    rst = 1'b0;
    rdy = 1'b1;
    cyc(3);
    chk("t1 none out", 64'(ngot[0]), 64'd0);

    // Streaming.
    b0 = ngot[0];
    for (int i = 0; i < 8; i++)
      put(32'h11 + 32'(i), 5'd0);
    valid = 1'b0;
    cyc(2);
    chk("t2 n", 64'(ngot[0] - b0), 64'd8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2 out%0d", i),
          64'(got[0][b0+i]), 64'h11 + 64'(i));

    // Full and backpressure.
    b0 = ngot[0];
    rdy = 1'b0;
    put(32'h31, 5'd0);
    put(32'h32, 5'd0);
    put(32'h33, 5'd0);
    chk("t3 full cnt", 64'(ch[0].bus.o_count), 64'd2);
    chk("t3 full rdy", 64'(ch[0].bus.o_ready), 64'd0);
    rdy = 1'b1;
    cyc(1);
    rdy = 1'b0;
    chk("t3 pop cnt", 64'(ch[0].bus.o_count), 64'd1);
    cyc(1);
    valid = 1'b0;
    chk("t3 acc cnt", 64'(ch[0].bus.o_count), 64'd2);
    rdy = 1'b1;
    cyc(3);
    chk("t3 n", 64'(ngot[0] - b0), 64'd3);
    chk("t3 o0", 64'(got[0][b0]), 64'h31);
    chk("t3 o1", 64'(got[0][b0+1]), 64'h32);
    chk("t3 o2", 64'(got[0][b0+2]), 64'h33);

    // Exception sleep.
    b0 = ngot[0];
    rdy = 1'b0;
    put(32'h41, 5'd0);
    put(32'h42, 5'b10000);
    put(32'h43, 5'd0);
    chk("t4 slp rdy", 64'(ch[0].bus.o_ready), 64'd1);
    put(32'h44, 5'd0);
    valid = 1'b0;
    exc = 5'd0;
    chk("t4 sleep", 64'(ch[0].bus.o_sleep), 64'd1);
    chk("t4 count", 64'(ch[0].bus.o_count), 64'd2);
    rdy = 1'b1;
    cyc(3);
    chk("t4 n", 64'(ngot[0] - b0), 64'd2);
    chk("t4 o0", 64'(got[0][b0]), 64'h41);
    chk("t4 o1", 64'(got[0][b0+1]), 64'h42);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("t4 wake", 64'(ch[0].bus.o_sleep), 64'd0);
    put(32'h45, 5'd0);
    valid = 1'b0;
    cyc(2);
    chk("t4 E", 64'(got[0][b0+2]), 64'h45);

    // Fault flush.
    rdy = 1'b0;
    put(32'h51, 5'd0);
    put(32'h52, 5'd0);
    valid = 1'b0;
    flt = 1'b1;
    cyc(1);
    flt = 1'b0;
    chk("t5 count", 64'(ch[0].bus.o_count), 64'd0);
    chk("t5 valid", 64'(ch[0].bus.o_valid), 64'd0);
    chk("t5 sleep", 64'(ch[0].bus.o_sleep), 64'd1);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;

    // Clear and fault together with a push.
    b0 = ngot[0];
    put(32'h60, 5'd0);
    clr = 1'b1;
    flt = 1'b1;
    put(32'h61, 5'd0);
    clr = 1'b0;
    flt = 1'b0;
    valid = 1'b0;
    chk("t6 count", 64'(ch[0].bus.o_count), 64'd0);
    chk("t6 sleep", 64'(ch[0].bus.o_sleep), 64'd0);
    rdy = 1'b1;
    cyc(2);
    chk("t6 dropped", 64'(ngot[0] - b0), 64'd0);

    // DEPTH=3 pointer wrap.
    b1 = ngot[1];
    for (int i = 0; i < 10; i++)
      put(32'h70 + 32'(i), 5'd0);
    valid = 1'b0;
    cyc(2);
    chk("wrap n", 64'(ngot[1] - b1), 64'd10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("wrap o%0d", i),
          64'(got[1][b1+i]), 64'h70 + 64'(i));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
